ica_weight_update: RTL and testbench
====================================

ICA_WEIGHT_UPDATE -- requirements
Module: ica_weight_update

Interface
REQ-001 The block SHALL have parameter LOG2N, default 13, meaning number of whitened samples per pass N = 2^LOG2N (1..14).
REQ-002 The block SHALL have parameter FRAC, default 20, meaning fractional bits of every 26-bit signed sample/weight word (Q6.20).
REQ-003 The block SHALL have port CLK_update  input  1  meaning single clock, rising edge active.
REQ-004 The block SHALL have port RST_update  input  1  meaning reset, asynchronous, active-high.
REQ-005 The block SHALL have port GO_update  input  1  meaning start pulse, sampled on rising edge of CLK_update.
REQ-006 The block SHALL have ports W1..W4  input  26 each, signed  meaning current weight vector w.
REQ-007 The block SHALL have ports Z1..Z4  input  26 each, signed  meaning whitened sample read from the whitened-data RAM, valid one cycle after addr.
REQ-008 The block SHALL have port addr  output  14  meaning whitened-data RAM read address.
REQ-009 The block SHALL have port En_rd  output  1  meaning RAM read enable.
REQ-010 The block SHALL have ports Wn1..Wn4  output  26 each, signed  meaning updated weight w+.
REQ-011 The block SHALL have port Update_busy  output  1  meaning pass in progress.
REQ-012 The block SHALL have port Update_done  output  1  meaning one-cycle pulse, Wn valid.

Function
REQ-013 The block SHALL compute w+ = mean(z*g(y)) - mean(g'(y))*w, with y = w.z, g(y) = y^3, g'(y) = 3*y^2, over samples at addresses 0..N-1.
REQ-014 The FSM SHALL have states IDLE, READ, DRAIN, FINISH: IDLE->READ on GO_update high; READ->DRAIN after addr N-1 is issued; DRAIN->FINISH after 4 cycles; FINISH->IDLE after 1 cycle.
REQ-015 W1..W4 SHALL be captured on the edge GO_update is sampled; later changes to W1..W4 SHALL NOT affect the pass.
REQ-016 In READ, En_rd SHALL be 1 and addr SHALL step 0,1,...,N-1, one per cycle, starting with the edge GO_update is sampled; in all other states En_rd = 0 and addr = 0.
REQ-017 The datapath SHALL be a 4-stage pipeline: S1 y = sum(Wi*Zi)>>>FRAC; S2 y2 = (y*y)>>>FRAC; S3 y3 = (y2*y)>>>FRAC and g' = 3*y2; S4 accumulate. Z SHALL be delayed to align with y3.
REQ-018 y, y2 and y3 SHALL be saturated to 26-bit signed; g' SHALL be kept 28-bit signed; all products SHALL be full width before an arithmetic right shift (truncation toward -inf).
REQ-019 Accumulators acc1..acc4 (sum of (Zi*y3)>>>FRAC) and accg (sum of g') SHALL be 56-bit signed, cleared on GO_update acceptance, and SHALL NOT wrap for any input.
REQ-020 In FINISH, the block SHALL compute Wni = sat26((acci>>>LOG2N) - (((accg>>>LOG2N)*Wi)>>>FRAC)), with sat26 clamping to [-2^25, 2^25-1].
REQ-021 Update_busy SHALL be 1 from the edge GO_update is accepted until Update_done is asserted, and 0 on that edge.
REQ-022 Update_done SHALL pulse high for exactly one cycle, N+6 rising edges after the edge at which GO_update was sampled.
REQ-023 Wn1..Wn4 SHALL update on the Update_done edge and hold until the next Update_done or reset.
REQ-024 GO_update while Update_busy = 1 SHALL be ignored, with no effect on timing or result.
REQ-025 GO_update held high SHALL start back-to-back passes, one new pass per IDLE cycle.

Reset
REQ-026 While RST_update = 1, the block SHALL force state IDLE, addr = 0, En_rd = 0, Update_busy = 0, Update_done = 0, Wn1..Wn4 = 0, all accumulators and pipeline registers = 0.
REQ-027 Reset asserted mid-pass SHALL abort the pass with no Update_done; the next GO_update after release SHALL produce a correct result.

Verification (LOG2N = 4, N = 16, FRAC = 20)
REQ-028 Reset test: assert RST_update asynchronously -> all outputs 0 immediately, without a clock edge.
REQ-029 Constant test: Z = (2^20,0,0,0) at every address, W = (2^20,0,0,0) -> Wn = (-2^21,0,0,0) (1 - 3 = -2.0), Update_done at edge 22, addr 0..15 seen once each.
REQ-030 Alternating test: Z1 = +/-2^20 alternating, other Zi = 0, W = (2^19,0,0,0) -> Wn1 = 0.125 - 0.75*0.5 = -0.25 = -2^18, other Wn = 0.
REQ-031 Saturation test: Z = (2^21,0,0,0), W = (2^21,0,0,0) (y3 saturates at 2^25-1; 64 - 96 < -32) -> Wn1 = -33554432.
REQ-032 Busy and re-GO test: pulse GO_update again at edge 5 of a pass -> ignored; Update_done still at edge 22; identical result.
REQ-033 Abort test: assert RST_update while addr = 7 -> Update_busy = 0, no Update_done; re-run constant test -> Wn = (-2^21,0,0,0).

Source files
------------

// File: rtl/ica_weight_update.sv
// FastICA one-unit weight update: streams N whitened samples through a 4-stage
// cubic-nonlinearity pipeline and forms w+ = E{z*g(w.z)} - E{g'(w.z)}*w.
module ica_weight_update #(
    parameter int LOG2N = 13,
    parameter int FRAC  = 20
) (
    input  logic               CLK_update,
    input  logic               RST_update,
    input  logic               GO_update,
    input  logic signed [25:0] W1,
    input  logic signed [25:0] W2,
    input  logic signed [25:0] W3,
    input  logic signed [25:0] W4,
    input  logic signed [25:0] Z1,
    input  logic signed [25:0] Z2,
    input  logic signed [25:0] Z3,
    input  logic signed [25:0] Z4,
    output logic [13:0]        addr,
    output logic               En_rd,
    output logic signed [25:0] Wn1,
    output logic signed [25:0] Wn2,
    output logic signed [25:0] Wn3,
    output logic signed [25:0] Wn4,
    output logic               Update_busy,
    output logic               Update_done
);
    localparam int          N    = 1 << LOG2N;
    localparam logic [13:0] LAST = 14'(N - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

    function automatic logic signed [25:0] sat26(input logic signed [63:0] v);
        if (v > 64'sd33554431)       return 26'sh1FFFFFF;
        else if (v < -64'sd33554432) return 26'sh2000000;
        else                         return v[25:0];
    endfunction

    state_t      state_q, state_d;
    logic [13:0] cnt_q, cnt_d, addr_q, addr_d;
    logic        en_q, en_d, busy_q, busy_d, fin_q, done_q, start;

    logic signed [25:0] w_in [4];
    logic signed [25:0] z_in [4];
    logic signed [25:0] w_q [4];
    logic signed [25:0] z1_q [4], z2_q [4], z3_q [4];
    logic signed [25:0] y_q, yd_q, y2_q, y3_q;
    logic signed [27:0] gp_q;
    logic               zv_q, v1_q, v2_q, v3_q;
    logic signed [55:0] acc_q [4];
    logic signed [55:0] accg_q;
    logic signed [55:0] mz_q [4];
    logic signed [63:0] pg_q [4];
    logic signed [25:0] wn_q [4];

    assign w_in[0] = W1;
    assign w_in[1] = W2;
    assign w_in[2] = W3;
    assign w_in[3] = W4;
    assign z_in[0] = Z1;
    assign z_in[1] = Z2;
    assign z_in[2] = Z3;
    assign z_in[3] = Z4;

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; no latches can form.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = '0;
        en_d    = 1'b0;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (GO_update && !busy_q) begin
                    start   = 1'b1;
                    state_d = READ;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                end
            end
            READ: begin
                if (cnt_q == LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + 14'd1;
                    addr_d = cnt_q + 14'd1;
                    en_d   = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == 14'd3) begin
                    state_d = FINISH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Busy stays up through the output stage and drops with the done pulse.
        busy_d = start ? 1'b1 : (fin_q ? 1'b0 : busy_q);
    end

    always_ff @(posedge CLK_update or posedge RST_update) begin
        if (RST_update) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            fin_q   <= (state_q == FINISH);
            done_q  <= fin_q;
        end
    end

    logic signed [53:0] dot;
    logic signed [51:0] yy, y2y;
    logic signed [25:0] y_d, y2_d, y3_d;
    logic signed [55:0] term [4];
    logic signed [55:0] mg;

    always_comb begin
        dot = '0;
        for (int i = 0; i < 4; i++) dot = dot + 54'(w_q[i]) * 54'(z_in[i]);
        y_d  = sat26(64'(dot >>> FRAC));
        yy   = 52'(y_q) * 52'(y_q);
        y2_d = sat26(64'(yy >>> FRAC));
        y2y  = 52'(y2_q) * 52'(yd_q);
        y3_d = sat26(64'(y2y >>> FRAC));
        mg   = accg_q >>> LOG2N;
        for (int i = 0; i < 4; i++) term[i] = 56'((52'(z3_q[i]) * 52'(y3_q)) >>> FRAC);
    end

    always_ff @(posedge CLK_update or posedge RST_update) begin
        if (RST_update) begin
            // NOTE: pipeline and accumulator arrays are reset too, so an aborted pass leaves no residue.
            for (int i = 0; i < 4; i++) begin
                w_q[i]   <= '0;
                z1_q[i]  <= '0;
                z2_q[i]  <= '0;
                z3_q[i]  <= '0;
                acc_q[i] <= '0;
                mz_q[i]  <= '0;
                pg_q[i]  <= '0;
                wn_q[i]  <= '0;
            end
            y_q    <= '0;
            yd_q   <= '0;
            y2_q   <= '0;
            y3_q   <= '0;
            gp_q   <= '0;
            zv_q   <= 1'b0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            accg_q <= '0;
        end else begin
            zv_q <= en_q;
            v1_q <= zv_q;
            v2_q <= v1_q;
            v3_q <= v2_q;
            y_q  <= y_d;
            yd_q <= y_q;
            y2_q <= y2_d;
            y3_q <= y3_d;
            gp_q <= 28'(y2_q) * 28'sd3;
            for (int i = 0; i < 4; i++) begin
                if (start) w_q[i] <= w_in[i];
                z1_q[i] <= z_in[i];
                z2_q[i] <= z1_q[i];
                z3_q[i] <= z2_q[i];
                if (start)     acc_q[i] <= '0;
                else if (v3_q) acc_q[i] <= acc_q[i] + term[i];
                if (state_q == FINISH) begin
                    mz_q[i] <= acc_q[i] >>> LOG2N;
                    pg_q[i] <= 64'((82'(mg) * 82'(w_q[i])) >>> FRAC);
                end
                if (fin_q) wn_q[i] <= sat26(64'(mz_q[i]) - pg_q[i]);
            end
            if (start)     accg_q <= '0;
            else if (v3_q) accg_q <= accg_q + 56'(gp_q);
        end
    end

    assign addr        = addr_q;
    assign En_rd       = en_q;
    assign Update_busy = busy_q;
    assign Update_done = done_q;
    assign Wn1         = wn_q[0];
    assign Wn2         = wn_q[1];
    assign Wn3         = wn_q[2];
    assign Wn4         = wn_q[3];

endmodule

// File: tb/tb_ica_weight_update.sv
// Bench for ica_weight_update (N = 16, Q6.20): directed corner passes plus random
// passes, each checked against an arithmetic reference model of the update rule.
`timescale 1ns/1ps
module tb_ica_weight_update;
    localparam int LOG2N = 4;
    localparam int N     = 16;
    localparam int FRAC  = 20;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               go  = 1'b0;
    logic signed [25:0] w_in [4];
    logic signed [25:0] z_in [4];
    logic [13:0]        addr;
    logic               en_rd;
    logic signed [25:0] wn [4];
    logic               busy, done;

    ica_weight_update #(.LOG2N(LOG2N), .FRAC(FRAC)) dut (
        .CLK_update(clk), .RST_update(rst), .GO_update(go),
        .W1(w_in[0]), .W2(w_in[1]), .W3(w_in[2]), .W4(w_in[3]),
        .Z1(z_in[0]), .Z2(z_in[1]), .Z3(z_in[2]), .Z4(z_in[3]),
        .addr(addr), .En_rd(en_rd),
        .Wn1(wn[0]), .Wn2(wn[1]), .Wn3(wn[2]), .Wn4(wn[3]),
        .Update_busy(busy), .Update_done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read whitened-data RAM: data appears one cycle after the address.
    logic signed [25:0] mem [4][N];
    always @(posedge clk) begin
        if (en_rd) for (int i = 0; i < 4; i++) z_in[i] <= mem[i][addr[LOG2N-1:0]];
    end

    int     total = 0, passed = 0, failed = 0;
    longint ref_w [4];
    longint exp_wn [4];
    int     hits [N];
    int     done_edge, done_cnt, busy_pre;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 33554431)  return 33554431;
        if (v < -33554432) return -33554432;
        return v;
    endfunction

    task automatic compute_expected();
        longint acc [4];
        longint accg, dot, y, y2, y3;
        accg = 0;
        for (int i = 0; i < 4; i++) acc[i] = 0;
        for (int s = 0; s < N; s++) begin
            dot = 0;
            for (int i = 0; i < 4; i++) dot += ref_w[i] * longint'(mem[i][s]);
            y  = sat(dot >>> FRAC);
            y2 = sat((y * y) >>> FRAC);
            y3 = sat((y2 * y) >>> FRAC);
            accg += 3 * y2;
            for (int i = 0; i < 4; i++) acc[i] += (longint'(mem[i][s]) * y3) >>> FRAC;
        end
        for (int i = 0; i < 4; i++)
            exp_wn[i] = sat((acc[i] >>> LOG2N) - (((accg >>> LOG2N) * ref_w[i]) >>> FRAC));
    endtask

    task automatic fill_const(input longint z1, input longint w1);
        for (int s = 0; s < N; s++) begin
            mem[0][s] = 26'(z1);
            for (int i = 1; i < 4; i++) mem[i][s] = '0;
        end
        ref_w[0] = w1;
        for (int i = 1; i < 4; i++) ref_w[i] = 0;
    endtask

    task automatic fill_random(input int range);
        int v;
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < N; s++) begin
                v = int'($urandom_range(0, 2 * range)) - range;
                mem[i][s] = 26'(v);
            end
            v = int'($urandom_range(0, 2 * range)) - range;
            ref_w[i] = v;
        end
    endtask

    // One pass from a GO pulse; regap > 0 re-pulses GO at that edge number.
    task automatic run_pass(input string tag, input int regap);
        int once;
        compute_expected();
        for (int a = 0; a < N; a++) hits[a] = 0;
        done_edge = -1;
        done_cnt  = 0;
        busy_pre  = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) w_in[i] = 26'(ref_w[i]);
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        for (int i = 0; i < 4; i++) w_in[i] = 26'($urandom);
        check({tag, "_busy_at_go"}, busy, 1);
        if (en_rd) hits[addr[LOG2N-1:0]]++;
        for (int e = 1; e <= N + 12; e++) begin
            if (e == regap) go = 1'b1;
            @(posedge clk); #1;
            if (e == regap) go = 1'b0;
            if (en_rd) hits[addr[LOG2N-1:0]]++;
            if (e == N + 5) busy_pre = busy;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
        end
        once = 0;
        for (int a = 0; a < N; a++) if (hits[a] == 1) once++;
        check({tag, "_done_edge"}, done_edge, N + 6);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_before_done"}, busy_pre, 1);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_addr_once"}, once, N);
        for (int i = 0; i < 4; i++) check($sformatf("%s_wn%0d", tag, i + 1), wn[i], exp_wn[i]);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 4; i++) w_in[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy_held", busy, 0);
        check("rst_en_held", en_rd, 0);
        @(negedge clk) rst = 1'b0;
        #1;
        check("rst_addr", addr, 0);
        check("rst_done", done, 0);
        check("rst_wn1", wn[0], 0);

        fill_const(1048576, 1048576);
        run_pass("const", 0);
        check("const_wn1_value", wn[0], -2097152);

        for (int s = 0; s < N; s++) mem[0][s] = (s % 2 == 0) ? 26'sd1048576 : -26'sd1048576;
        ref_w[0] = 524288;
        run_pass("alt", 0);
        check("alt_wn1_value", wn[0], -262144);

        fill_const(2097152, 2097152);
        run_pass("sat", 0);
        check("sat_wn1_value", wn[0], -33554432);

        fill_random(1 << 19);
        run_pass("rand_small", 0);
        fill_random(1 << 21);
        run_pass("rand_wide", 0);

        // Asynchronous reset clears outputs with no clock edge in between.
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("async_rst_wn%0d", i + 1), wn[i], 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_addr", addr, 0);
        check("async_rst_en", en_rd, 0);
        @(negedge clk) rst = 1'b0;

        fill_const(1048576, 1048576);
        run_pass("rego", 5);
        check("rego_wn1_value", wn[0], -2097152);

        // Abort a pass mid-read, then confirm the next pass is clean.
        @(negedge clk);
        for (int i = 0; i < 4; i++) w_in[i] = 26'(ref_w[i]);
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        k = 0;
        while (addr != 14'd7 && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        check("abort_reached_addr7", addr, 7);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        @(negedge clk) rst = 1'b0;
        done_cnt = 0;
        for (int e = 0; e < N + 12; e++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        run_pass("after_abort", 0);
        check("after_abort_wn1_value", wn[0], -2097152);

        // GO held high: two complete passes must follow each other.
        fill_random(1 << 20);
        compute_expected();
        @(negedge clk);
        for (int i = 0; i < 4; i++) w_in[i] = 26'(ref_w[i]);
        go = 1'b1;
        done_cnt = 0;
        for (int e = 0; e <= 2 * N + 30 && done_cnt < 2; e++) begin
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) check("b2b_first_wn1", wn[0], exp_wn[0]);
            end
        end
        go = 1'b0;
        check("b2b_done_count", done_cnt, 2);
        for (int i = 0; i < 4; i++) check($sformatf("b2b_second_wn%0d", i + 1), wn[i], exp_wn[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
